// File: rtl/ahb_bram_pkg.sv
// Shared types, default width and byte-lane merge helper for the BRAM store.
package ahb_bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bram_state_t;

  localparam int BRAM_ADDR_WIDTH_DEF = 12;

  // Lanes with be[n]=1 take new_data, the rest keep old_data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_data,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_data;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) merged[8*n +: 8] = new_data[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_byte_array.sv
// Inferable byte-lane simple-dual-port RAM, read-old-data, no reset.
// Kept standalone so a vendor macro can be dropped in its place.
module bram_byte_array
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (we[n]) mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_bram_store.sv
// Word store behind the AHB-Lite BRAM bridge: zero-fill after reset,
// byte-lane writes, 1-cycle reads with write-first bypass.
module ahb_bram_store
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  input  logic [31:0]           BRAM_WDATA,
  input  logic [3:0]            BRAM_WRITE,
  output logic [31:0]           BRAM_RDATA,
  output logic                  INIT_DONE
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

  bram_state_t           state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rd_valid;
  logic [3:0]            byp_be;
  logic [31:0]           byp_data;

  logic [3:0]            arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [31:0]           arr_wdata;
  logic [31:0]           arr_rdata;

  // Writes are suppressed while in reset so the array really is untouched.
  always_comb begin
    arr_we    = BRAM_WRITE;
    arr_waddr = BRAM_WRADDR;
    arr_wdata = BRAM_WDATA;
    if (!HRESETn) begin
      arr_we = 4'h0;
    end else if (state == CLEAR) begin
      arr_we    = 4'hF;
      arr_waddr = clr_cnt;
      arr_wdata = 32'h0;
    end
  end

  bram_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (HCLK),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (BRAM_RDADDR),
    .rdata (arr_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= INIT_ZERO ? CLEAR : READY;
      clr_cnt  <= '0;
      rd_valid <= 1'b0;
      byp_be   <= 4'h0;
      byp_data <= 32'h0;
    end else begin
      case (state)
        CLEAR: begin
          rd_valid <= 1'b0;
          byp_be   <= 4'h0;
          if (clr_cnt == LAST_WORD) state <= READY;
          else clr_cnt <= clr_cnt + 1'b1;
        end
        READY: begin
          rd_valid <= 1'b1;
          byp_be   <= (BRAM_WRADDR == BRAM_RDADDR) ? BRAM_WRITE : 4'h0;
          byp_data <= BRAM_WDATA;
        end
        default: state <= READY;
      endcase
    end
  end

  // The array returns pre-edge data; overlay any lanes written on that same edge.
  assign BRAM_RDATA = rd_valid ? lane_merge(arr_rdata, byp_data, byp_be) : 32'h0;
  assign INIT_DONE  = (state == READY);

endmodule

// File: tb/tb_ahb_bram_store.sv
// Directed scoreboard bench for ahb_bram_store (INIT_ZERO=1 and INIT_ZERO=0 instances).
module tb_ahb_bram_store;
  import ahb_bram_pkg::*;

  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] BRAM_RDADDR;
  logic [AW-1:0] BRAM_WRADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;
  logic [31:0]   BRAM_RDATA;
  logic          INIT_DONE;
  logic [31:0]   rdata_nz;
  logic          done_nz;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];
  logic [31:0] model [int];
  bit model_ready = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_bram_store #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .BRAM_RDADDR (BRAM_RDADDR),
    .BRAM_WRADDR (BRAM_WRADDR),
    .BRAM_WDATA  (BRAM_WDATA),
    .BRAM_WRITE  (BRAM_WRITE),
    .BRAM_RDATA  (BRAM_RDATA),
    .INIT_DONE   (INIT_DONE)
  );

  ahb_bram_store #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b0)) dut_nz (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .BRAM_RDADDR (BRAM_RDADDR),
    .BRAM_WRADDR (BRAM_WRADDR),
    .BRAM_WDATA  (BRAM_WDATA),
    .BRAM_WRITE  (BRAM_WRITE),
    .BRAM_RDATA  (rdata_nz),
    .INIT_DONE   (done_nz)
  );

  function automatic logic [31:0] model_read(input int a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; entered and left on a falling edge.
  task automatic apply_stimulus(input logic [AW-1:0] wa, input logic [31:0] wd,
                                input logic [3:0] we, input logic [AW-1:0] ra);
    BRAM_WRADDR = wa;
    BRAM_WDATA  = wd;
    BRAM_WRITE  = we;
    BRAM_RDADDR = ra;
    @(posedge HCLK);
    if (model_ready && HRESETn && we != 4'h0)
      model[int'(wa)] = lane_merge(model_read(int'(wa)), wd, we);
    @(negedge HCLK);
  endtask

  task automatic read_expect(input string tag, input logic [AW-1:0] ra, input logic [31:0] exp);
    sb.push_back(exp);
    apply_stimulus('0, 32'h0, 4'h0, ra);
    check_output(tag, BRAM_RDATA, sb.pop_front());
  endtask

  task automatic run_clear(input string tag);
    for (int i = 1; i <= 4095; i++) begin
      if (i >= 10 && i <= 20) apply_stimulus(12'd3, 32'hFFFF_FFFF, 4'hF, 12'd3);
      else apply_stimulus('0, 32'h0, 4'h0, 12'd3);
      if (i == 200) check_output({tag, "_rdata_held"}, BRAM_RDATA, 32'h0);
    end
    check_output({tag, "_done_4095"}, {31'h0, INIT_DONE}, 32'h0);
    apply_stimulus('0, 32'h0, 4'h0, 12'd3);
    check_output({tag, "_done_4096"}, {31'h0, INIT_DONE}, 32'h1);
    model.delete();
    model_ready = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    BRAM_RDADDR = '0;
    BRAM_WRADDR = '0;
    BRAM_WDATA  = 32'h0;
    BRAM_WRITE  = 4'h0;
    @(negedge HCLK);
    apply_stimulus('0, 32'h0, 4'h0, '0);
    apply_stimulus('0, 32'h0, 4'h0, '0);
    check_output("reset_done", {31'h0, INIT_DONE}, 32'h0);
    check_output("reset_rdata", BRAM_RDATA, 32'h0);
    check_output("nz_reset_done", {31'h0, done_nz}, 32'h1);
    check_output("nz_reset_rdata", rdata_nz, 32'h0);

    HRESETn = 1'b1;
    run_clear("clear1");
    read_expect("rd0_zero", 12'd0, 32'h0);
    read_expect("rd2048_zero", 12'd2048, 32'h0);
    read_expect("rd4095_zero", 12'd4095, 32'h0);
    read_expect("rd3_ignored_wr", 12'd3, 32'h0);

    apply_stimulus(12'd5, 32'hDEAD_BEEF, 4'hF, 12'd0);
    read_expect("rd5_full", 12'd5, 32'hDEAD_BEEF);
    apply_stimulus(12'd5, 32'h0000_00AA, 4'h1, 12'd0);
    read_expect("rd5_lane0", 12'd5, 32'hDEAD_BEAA);
    apply_stimulus(12'd5, 32'h1234_0000, 4'hC, 12'd0);
    read_expect("rd5_lane23", 12'd5, 32'h1234_BEAA);

    apply_stimulus(12'd7, 32'h1122_3344, 4'hF, 12'd0);
    sb.push_back(32'hAABB_3344);
    apply_stimulus(12'd7, 32'hAABB_CCDD, 4'hC, 12'd7);
    check_output("bypass_same_edge", BRAM_RDATA, sb.pop_front());
    read_expect("rd7_after_bypass", 12'd7, 32'hAABB_3344);
    sb.push_back(32'h5566_7788);
    apply_stimulus(12'd8, 32'h5566_7788, 4'hF, 12'd7);
    check_output("no_bypass_other_addr", BRAM_RDATA, 32'hAABB_3344);
    read_expect("rd8", 12'd8, sb.pop_front());

    apply_stimulus(12'd4095, 32'hCAFE_F00D, 4'hF, 12'd0);
    apply_stimulus(12'd0, 32'h0BAD_BEEF, 4'hF, 12'd0);
    read_expect("rd4095_top", 12'd4095, 32'hCAFE_F00D);
    read_expect("rd0_bottom", 12'd0, 32'h0BAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] a;
      a = AW'(16 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        apply_stimulus(a, $urandom, 4'($urandom_range(1, 15)), 12'd0);
      else
        read_expect("rand_read", a, model_read(int'(a)));
    end

    apply_stimulus(12'd4000, 32'h1234_5678, 4'hF, 12'd0);
    read_expect("rd4000_pre_reset", 12'd4000, 32'h1234_5678);

    // Abort a sweep at edge 100 and require a complete fresh sweep.
    model_ready = 1'b0;
    HRESETn = 1'b0;
    apply_stimulus('0, 32'h0, 4'h0, 12'd4000);
    HRESETn = 1'b1;
    for (int i = 1; i <= 99; i++) apply_stimulus('0, 32'h0, 4'h0, 12'd4000);
    HRESETn = 1'b0;
    apply_stimulus('0, 32'h0, 4'h0, 12'd4000);
    check_output("midclear_reset_done", {31'h0, INIT_DONE}, 32'h0);
    check_output("midclear_reset_rdata", BRAM_RDATA, 32'h0);
    HRESETn = 1'b1;
    run_clear("clear2");
    read_expect("rd4000_cleared", 12'd4000, 32'h0);
    read_expect("rd5_cleared", 12'd5, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
